// File: rtl/dds_tune_arbiter.sv
// DDS tuning-word arbiter: grants host/CPU FTW updates and commits them on
// DDS sample ticks, ramping by at most step_max_i per tick.
module dds_tune_arbiter #(
  parameter int unsigned g_tune_width = 48,
  parameter logic [63:0] g_reset_tune = '0
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    host_req_i,
  input  logic [g_tune_width-1:0] host_tune_i,
  output logic                    host_ack_o,
  input  logic                    cpu_req_i,
  input  logic [g_tune_width-1:0] cpu_tune_i,
  output logic                    cpu_ack_o,
  input  logic                    cfg_cpu_prio_i,
  input  logic [g_tune_width-1:0] step_max_i,
  input  logic                    tick_i,
  output logic [g_tune_width-1:0] dds_tune_o,
  output logic                    dds_load_o,
  output logic                    busy_o,
  output logic [31:0]             stat_commits_o
);

  localparam int unsigned W = g_tune_width;
  localparam logic [W-1:0] ResetTune = W'(g_reset_tune);

  typedef enum logic [1:0] {StIdle, StWaitTick, StSlew} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   tune_q, tune_d;
  logic [W-1:0]   target_q, target_d;
  logic           host_ack_q, host_ack_d;
  logic           cpu_ack_q, cpu_ack_d;
  logic           load_q, load_d;
  logic [31:0]    commits_q, commits_d;

  // Both operands are < 2^W, so the W+1 bit difference never wraps; MSB is the sign.
  logic [W:0]     delta;
  logic [W:0]     delta_mag;
  logic           within_step;

  // Signed distance to target and whether it fits in one step.
  always_comb begin
    delta       = {1'b0, target_q} - {1'b0, tune_q};
    delta_mag   = delta[W] ? (~delta + (W+1)'(1)) : delta;
    within_step = (step_max_i == '0) || (delta_mag <= {1'b0, step_max_i});
  end

  // Next-state: grant in idle, then commit or slew on each tick.
  always_comb begin
    state_d    = state_q;
    tune_d     = tune_q;
    target_d   = target_q;
    host_ack_d = 1'b0;
    cpu_ack_d  = 1'b0;
    load_d     = 1'b0;
    commits_d  = commits_q;
    unique case (state_q)
      StIdle: begin
        if (host_req_i || cpu_req_i) begin
          if (cpu_req_i && (cfg_cpu_prio_i || !host_req_i)) begin
            target_d  = cpu_tune_i;
            cpu_ack_d = 1'b1;
          end else begin
            target_d   = host_tune_i;
            host_ack_d = 1'b1;
          end
          state_d = StWaitTick;
        end
      end
      StWaitTick, StSlew: begin
        if (tick_i) begin
          load_d = 1'b1;
          if (within_step) begin
            tune_d    = target_q;
            commits_d = commits_q + 32'd1;
            state_d   = StIdle;
          end else begin
            // |delta| > step, so neither direction can leave the W-bit range.
            tune_d  = delta[W] ? (tune_q - step_max_i) : (tune_q + step_max_i);
            state_d = StSlew;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      tune_q     <= ResetTune;
      target_q   <= ResetTune;
      host_ack_q <= 1'b0;
      cpu_ack_q  <= 1'b0;
      load_q     <= 1'b0;
      commits_q  <= '0;
    end else begin
      state_q    <= state_d;
      tune_q     <= tune_d;
      target_q   <= target_d;
      host_ack_q <= host_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      load_q     <= load_d;
      commits_q  <= commits_d;
    end
  end

  assign host_ack_o     = host_ack_q;
  assign cpu_ack_o      = cpu_ack_q;
  assign dds_tune_o     = tune_q;
  assign dds_load_o     = load_q;
  assign busy_o         = (state_q != StIdle);
  assign stat_commits_o = commits_q;

endmodule

// File: tb/tb_dds_tune_arbiter.sv
// Randomized and directed bench for dds_tune_arbiter against a transaction-level model.
module tb_dds_tune_arbiter;

  localparam int unsigned W = 32;
  localparam logic [63:0] ResetTune = 64'h1234;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         host_req = 1'b0;
  logic [W-1:0] host_tune = '0;
  logic         cpu_req = 1'b0;
  logic [W-1:0] cpu_tune = '0;
  logic         cfg_cpu_prio = 1'b0;
  logic [W-1:0] step_max = '0;
  logic         tick = 1'b0;
  logic         host_ack, cpu_ack, dds_load, busy;
  logic [W-1:0] dds_tune;
  logic [31:0]  commits;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: current/target FTW as plain integers, and whether an update is in flight.
  longint      m_tune, m_target;
  bit          m_busy, m_host_ack, m_cpu_ack, m_load;
  logic [31:0] m_commits;

  dds_tune_arbiter #(
    .g_tune_width(W),
    .g_reset_tune(ResetTune)
  ) dut (
    .clk_sys_i     (clk),
    .rst_n_i       (rst_n),
    .host_req_i    (host_req),
    .host_tune_i   (host_tune),
    .host_ack_o    (host_ack),
    .cpu_req_i     (cpu_req),
    .cpu_tune_i    (cpu_tune),
    .cpu_ack_o     (cpu_ack),
    .cfg_cpu_prio_i(cfg_cpu_prio),
    .step_max_i    (step_max),
    .tick_i        (tick),
    .dds_tune_o    (dds_tune),
    .dds_load_o    (dds_load),
    .busy_o        (busy),
    .stat_commits_o(commits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tune     = longint'(ResetTune);
    m_target   = longint'(ResetTune);
    m_busy     = 1'b0;
    m_host_ack = 1'b0;
    m_cpu_ack  = 1'b0;
    m_load     = 1'b0;
    m_commits  = '0;
  endtask

  // One clock of the arbitration rules, from the inputs present at the edge.
  task automatic model_step();
    longint rem, mag, stp;
    m_host_ack = 1'b0;
    m_cpu_ack  = 1'b0;
    m_load     = 1'b0;
    stp        = longint'(step_max);
    if (!m_busy) begin
      if (host_req || cpu_req) begin
        if (cpu_req && (cfg_cpu_prio || !host_req)) begin
          m_target  = longint'(cpu_tune);
          m_cpu_ack = 1'b1;
        end else begin
          m_target   = longint'(host_tune);
          m_host_ack = 1'b1;
        end
        m_busy = 1'b1;
      end
    end else if (tick) begin
      rem    = m_target - m_tune;
      mag    = (rem < 0) ? -rem : rem;
      m_load = 1'b1;
      if (stp == 0 || mag <= stp) begin
        m_tune    = m_target;
        m_commits = m_commits + 32'd1;
        m_busy    = 1'b0;
      end else begin
        m_tune = (rem < 0) ? m_tune - stp : m_tune + stp;
      end
    end
  endtask

  task automatic compare_all();
    check("dds_tune", 64'(dds_tune), 64'(m_tune));
    check("dds_load", 64'(dds_load), 64'(m_load));
    check("host_ack", 64'(host_ack), 64'(m_host_ack));
    check("cpu_ack",  64'(cpu_ack),  64'(m_cpu_ack));
    check("busy",     64'(busy),     64'(m_busy));
    check("commits",  64'(commits),  64'(m_commits));
  endtask

  // One cycle with optional tick; requesters drop req the cycle after their ack.
  task automatic cyc(input bit t);
    tick = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    tick = 1'b0;
    if (m_host_ack) host_req = 1'b0;
    if (m_cpu_ack)  cpu_req  = 1'b0;
  endtask

  task automatic run_ticks(input int n, input int period);
    for (int i = 0; i < n; i++) cyc((i % period) == period - 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tune"},    64'(dds_tune), ResetTune);
    check({tag, "_load"},    64'(dds_load), 64'd0);
    check({tag, "_busy"},    64'(busy),     64'd0);
    check({tag, "_acks"},    64'({host_ack, cpu_ack}), 64'd0);
    check({tag, "_commits"}, 64'(commits),  64'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ticks while idle do nothing.
    cyc(1); cyc(1); cyc(1);

    // Single host update; tick in the grant cycle is ignored.
    host_req  = 1'b1;
    host_tune = 32'h1000_0000;
    step_max  = '0;
    cyc(1);
    cyc(0); cyc(0); cyc(0); cyc(0);
    cyc(1);
    check("single_tune", 64'(dds_tune), 64'h1000_0000);
    check("single_commits", 64'(commits), 64'd1);

    // Simultaneous requests, both priority settings.
    for (int p = 1; p >= 0; p--) begin
      cfg_cpu_prio = 1'(p);
      host_req = 1'b1; host_tune = 32'h100;
      cpu_req  = 1'b1; cpu_tune  = 32'h200;
      run_ticks(12, 3);
      check("prio_final", 64'(dds_tune), (p == 1) ? 64'h100 : 64'h200);
    end
    check("prio_commits", 64'(commits), 64'd5);

    // Slew up from 0 to 0x1000 in 0x400 steps, then down to 0xA00.
    cpu_req = 1'b1; cpu_tune = '0; step_max = '0;
    run_ticks(4, 2);
    step_max = 32'h400;
    cpu_req = 1'b1; cpu_tune = 32'h1000;
    cyc(0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("slew_up", 64'(dds_tune), 64'(k * 32'h400));
      check("slew_up_busy", 64'(busy), (k < 4) ? 64'd1 : 64'd0);
    end
    cpu_req = 1'b1; cpu_tune = 32'h0A00;
    cyc(0);
    cyc(1); check("slew_dn1", 64'(dds_tune), 64'h0C00);
    cyc(1); check("slew_dn2", 64'(dds_tune), 64'h0A00);

    // Reset asserted mid-ramp, away from the clock edge.
    host_req = 1'b1; host_tune = 32'h8000; step_max = 32'h100;
    run_ticks(8, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    host_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    host_req = 1'b1; host_tune = 32'h2000; step_max = '0;
    run_ticks(4, 2);
    check("post_reset_tune", 64'(dds_tune), 64'h2000);

    // Commit counter wrap.
    force dut.commits_q = 32'hFFFF_FFFF;
    #1 release dut.commits_q;
    m_commits = 32'hFFFF_FFFF;
    cpu_req = 1'b1; cpu_tune = 32'h3000;
    run_ticks(4, 2);
    check("commits_wrap", 64'(commits), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (!host_req && $urandom_range(0, 7) == 0) begin
        host_req  = 1'b1;
        host_tune = W'($urandom_range(0, 32'hFFFF));
      end
      if (!cpu_req && $urandom_range(0, 7) == 0) begin
        cpu_req  = 1'b1;
        cpu_tune = W'($urandom_range(0, 32'hFFFF));
      end
      if ($urandom_range(0, 19) == 0)
        step_max = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(32'h80, 32'h2000));
      if ($urandom_range(0, 9) == 0) cfg_cpu_prio = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
